// File: rtl/busca_instrucao.sv
// Instruction fetch stage: holds the PC, drives the ROM address and captures the ROM
// word into the IF/ID register, with decode back-pressure, branch redirect and halt.
module busca_instrucao #(
    parameter int                 ADDR_W    = 4,
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  HALT_WORD = '0,
    parameter int                 CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] endereco,
    input  logic [DATA_W-1:0] instrucao,
    input  logic              desvio,
    input  logic [ADDR_W-1:0] alvo,
    input  logic              id_pronto,
    output logic              if_id_valido,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              parado,
    output logic [CNT_W-1:0]  contador
);

    // Handshake: if_id_* moves to decode on a cycle where if_id_valido=1 and id_pronto=1;
    // with if_id_valido=1 and id_pronto=0 everything holds; a bubble is always overwritten.
    typedef enum logic {FETCH, HALT} estado_t;

    estado_t           estado;
    logic [ADDR_W-1:0] pc;
    logic              stall;

    assign endereco = pc;
    assign stall    = if_id_valido & ~id_pronto;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado       <= FETCH;
            pc           <= '0;
            if_id_valido <= 1'b0;
            if_id_instr  <= '0;
            if_id_pc     <= '0;
            parado       <= 1'b0;
            contador     <= '0;
        end else begin
            case (estado)
                FETCH: begin
                    if (desvio) begin
                        // Whatever sits in IF/ID is on the wrong path, stalled or not.
                        pc           <= alvo;
                        if_id_valido <= 1'b0;
                    end else if (!stall) begin
                        if (instrucao == HALT_WORD) begin
                            if_id_valido <= 1'b0;
                            estado       <= HALT;
                            parado       <= 1'b1;
                        end else begin
                            if_id_instr  <= instrucao;
                            if_id_pc     <= pc;
                            if_id_valido <= 1'b1;
                            pc           <= pc + 1'b1;
                            if (contador != '1)
                                contador <= contador + 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (desvio) begin
                        pc     <= alvo;
                        estado <= FETCH;
                        parado <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the fetch stage and a ROM array.
module tb_busca_instrucao;

    logic        clk;
    logic        rst_n;
    logic [3:0]  endereco;
    logic [31:0] instrucao;
    logic        desvio;
    logic [3:0]  alvo;
    logic        id_pronto;
    logic        if_id_valido;
    logic [31:0] if_id_instr;
    logic [3:0]  if_id_pc;
    logic        parado;
    logic [7:0]  contador;

    logic [31:0] rom [16];

    int n_cmp;
    int n_bad;

    // Reference model state
    int          m_pc;
    bit          m_halt;
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_ipc;
    int          m_cnt;

    busca_instrucao dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .endereco    (endereco),
        .instrucao   (instrucao),
        .desvio      (desvio),
        .alvo        (alvo),
        .id_pronto   (id_pronto),
        .if_id_valido(if_id_valido),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .parado      (parado),
        .contador    (contador)
    );

    assign instrucao = rom[endereco];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load_shipped_rom();
        for (int i = 0; i < 16; i++)
            rom[i] = (i <= 12) ? (32'h1000_0001 + 32'(i) * 32'h0101_0111) : 32'h0;
    endtask

    // Apply inputs, advance one clock, update the model from the rules, compare all outputs.
    task automatic step(input logic r, input logic d, input logic [3:0] a, input logic p);
        logic [31:0] word;
        rst_n = r; desvio = d; alvo = a; id_pronto = p;
        word = rom[m_pc];
        @(posedge clk);
        if (!r) begin
            m_pc = 0; m_halt = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
        end else if (!m_halt) begin
            if (d) begin
                m_pc = int'(a); m_valid = 0;
            end else if (m_valid && !p) begin
                // decode busy: nothing moves
            end else if (word == 32'h0) begin
                m_valid = 0; m_halt = 1;
            end else begin
                m_instr = word; m_ipc = m_pc; m_valid = 1;
                m_pc = (m_pc + 1) % 16;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
        end else if (d) begin
            m_pc = int'(a); m_halt = 0;
        end
        #1;
        chk("endereco", 32'(endereco), 32'(m_pc));
        chk("valido",   32'(if_id_valido), 32'(m_valid));
        chk("instr",    if_id_instr, m_instr);
        chk("if_id_pc", 32'(if_id_pc), 32'(m_ipc));
        chk("parado",   32'(parado), 32'(m_halt));
        chk("contador", 32'(contador), 32'(m_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b1);
    endtask

    int cnt_before;

    initial begin
        n_cmp = 0; n_bad = 0;
        m_pc = 0; m_halt = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
        rst_n = 1'b0; desvio = 1'b0; alvo = 4'd0; id_pronto = 1'b1;
        load_shipped_rom();

        // T1: reset, run a little, reset again mid-run for 3 cycles
        step(1'b0, 1'b0, 4'd0, 1'b1);
        run(5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd9, 1'b0);
        chk("t1_endereco", 32'(endereco), 32'd0);
        chk("t1_contador", 32'(contador), 32'd0);
        run(1);
        chk("t1_first_word", if_id_instr, rom[0]);

        // T2: straight run into the halt word at 13
        run(14);
        chk("t2_parado", 32'(parado), 32'd1);
        chk("t2_endereco", 32'(endereco), 32'd13);
        chk("t2_contador", 32'(contador), 32'd13);
        run(3);

        // T3: stall after rom[2] captured
        step(1'b0, 1'b0, 4'd0, 1'b1);
        run(3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("t3_held_instr", if_id_instr, rom[2]);
        chk("t3_held_pc", 32'(endereco), 32'd3);
        run(1);
        chk("t3_release", if_id_instr, rom[3]);

        // T4: redirect pc=7 -> 8
        run(3);
        chk("t4_at7", 32'(endereco), 32'd7);
        cnt_before = int'(contador);
        step(1'b1, 1'b1, 4'd8, 1'b1);
        chk("t4_squash", 32'(if_id_valido), 32'd0);
        run(1);
        chk("t4_target", if_id_instr, rom[8]);
        chk("t4_count", 32'(contador), 32'(cnt_before + 1));

        // T5: redirect while stalled, then from HALT back to 0
        step(1'b1, 1'b1, 4'd2, 1'b0);
        chk("t5_stall_squash", 32'(if_id_valido), 32'd0);
        run(12);
        chk("t5_halted", 32'(parado), 32'd1);
        step(1'b1, 1'b1, 4'd0, 1'b0);
        chk("t5_unhalt", 32'(parado), 32'd0);
        run(1);
        chk("t5_rom0", if_id_instr, rom[0]);

        // Random traffic over random ROM images with sparse zero words
        for (int img = 0; img < 4; img++) begin
            for (int i = 0; i < 16; i++)
                rom[i] = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom() | 32'h1);
            for (int c = 0; c < 400; c++)
                step(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) == 0),
                     4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
        end

        // T6: all-non-zero ROM, wrap and saturate
        for (int i = 0; i < 16; i++) rom[i] = 32'hA500_0000 | 32'(i + 1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        run(300);
        chk("t6_saturate", 32'(contador), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
